// File: rtl/inst_byte_fifo.sv
// inst_byte_fifo: assembles 11-byte host stream into 82-bit words queued in a FWFT FIFO.
// Optional padding check on byte 10 enabled by INST_BYTE_FIFO_PAD_CHECK_EN.
module inst_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              read_en,
  output logic [81:0]       fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   word_count,
  output logic              pad_err
);
  logic [79:0]       asm_q;
  logic [3:0]        byte_cnt;
  logic [81:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              accept, last, pad_bad, push, pop;
  assign fifo_empty = word_count == '0;
  assign fifo_full  = word_count == (ADDR_W+1)'(DEPTH);
  assign byte_ready = (byte_cnt != 4'd10) || !fifo_full;
  assign accept     = byte_valid && byte_ready;
  assign last       = accept && byte_cnt == 4'd10;
`ifdef INST_BYTE_FIFO_PAD_CHECK_EN
  assign pad_bad    = |byte_in[7:2];
`else
  assign pad_bad    = 1'b0;
`endif
  assign push       = last && !pad_bad;
  assign pop        = read_en && !fifo_empty;
  assign fifo_data  = fifo_empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      byte_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
    end else begin
      if (accept) byte_cnt <= last ? 4'd0 : byte_cnt + 4'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      word_count <= word_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  end
  // after ten shifts byte 0 sits in [7:0]; no reset needed since byte_cnt gates use
  always_ff @(posedge clk) begin
    if (accept && !last) asm_q <= {byte_in, asm_q[79:8]};
    if (push) mem[wr_ptr] <= {byte_in[1:0], asm_q};
  end
`ifdef INST_BYTE_FIFO_PAD_CHECK_EN
  always_ff @(posedge clk) begin
    if (!n_rst) pad_err <= 1'b0;
    else if (last && pad_bad) pad_err <= 1'b1;
  end
`else
  assign pad_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_byte_fifo.sv
// tb_inst_byte_fifo: directed bench with a queue-level reference model checked every cycle.
module tb_inst_byte_fifo;
  localparam int DEPTH = 8;
  logic        clk = 0, n_rst = 0, byte_valid = 0, read_en = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_ready, fifo_empty, fifo_full, pad_err;
  logic [81:0] fifo_data;
  logic [3:0]  word_count;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [81:0] m_q[$];
  logic [7:0]  m_b[$];
  bit          m_pad = 0;

  inst_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .read_en(read_en), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .word_count(word_count),
    .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [81:0] act, logic [81:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // reference: byte list grows to 11, then becomes a word at the back of a word queue
  always @(posedge clk) begin : model
    logic [81:0] w;
    bit rdy;
    if (!n_rst) begin
      m_q.delete();
      m_b.delete();
      m_pad = 0;
    end else begin
      rdy = m_b.size() != 10 || m_q.size() != DEPTH;
      if (read_en && m_q.size() > 0) void'(m_q.pop_front());
      if (byte_valid && rdy) begin
        if (m_b.size() == 10) begin
          w = {byte_in[1:0], 80'h0};
          for (int k = 0; k < 10; k++) w[8*k +: 8] = m_b[k];
          m_b.delete();
`ifdef INST_BYTE_FIFO_PAD_CHECK_EN
          if (byte_in[7:2] != 0) m_pad = 1;
          else m_q.push_back(w);
`else
          m_q.push_back(w);
`endif
        end else m_b.push_back(byte_in);
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("byte_ready", byte_ready, (m_b.size() != 10 || m_q.size() != DEPTH));
    chk("fifo_data", fifo_data, m_q.size() > 0 ? m_q[0] : 82'h0);
    chk("word_count", word_count, m_q.size());
    chk("fifo_empty", fifo_empty, m_q.size() == 0);
    chk("fifo_full", fifo_full, m_q.size() == DEPTH);
    chk("pad_err", pad_err, m_pad);
  end

  task automatic step(bit v, logic [7:0] b, bit r);
    byte_valid = v;
    byte_in = b;
    read_en = r;
    @(negedge clk);
  endtask

  task automatic send_word(logic [7:0] base, logic [7:0] last);
    for (int k = 0; k < 10; k++) step(1, base + 8'(k), 0);
    step(1, last, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_ready", byte_ready, 1);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_data", fifo_data, 0);
    n_rst = 1;
    // first word, little-endian
    for (int k = 1; k <= 10; k++) step(1, 8'(k), 0);
    step(1, 8'h03, 0);
    chk("w1_count", word_count, 1);
    chk("w1_data", fifo_data, {2'b11, 80'h0A090807060504030201});
    step(0, 0, 1);
    // fill, then hold the 11th byte of a ninth word until a pop frees space
    for (int i = 0; i < 8; i++) send_word(8'(16 * i), 8'(i & 3));
    chk("full_flag", fifo_full, 1);
    for (int k = 0; k < 10; k++) step(1, 8'hA0 + 8'(k), 0);
    chk("full_stall", byte_ready, 0);
    step(1, 8'h02, 0);
    step(1, 8'h02, 0);
    step(1, 8'h02, 1);
    chk("stall_pop_ready", byte_ready, 1);
    chk("stall_pop_count", word_count, 7);
    step(1, 8'h02, 0);
    chk("ninth_word_count", word_count, 8);
    repeat (8) step(0, 0, 1);
    chk("drain_empty", fifo_empty, 1);
    // completing byte with read_en while empty
    for (int k = 0; k < 10; k++) step(1, 8'h30 + 8'(k), 0);
    step(1, 8'h01, 1);
    chk("wr_rd_empty_count", word_count, 1);
    chk("wr_rd_empty_data", fifo_data, {2'b01, 80'h39383736353433323130});
    step(0, 0, 1);
    // pointer wrap
    for (int i = 1; i <= 8; i++) send_word(8'(16 * i), 8'h01);
    repeat (3) step(0, 0, 1);
    chk("wrap_count5", word_count, 5);
    for (int i = 9; i <= 11; i++) send_word(8'(16 * i), 8'h01);
    chk("wrap_count8", word_count, 8);
    chk("wrap_head", fifo_data, {2'b01, 80'h49484746454443424140});
    repeat (8) step(0, 0, 1);
    // mid-word reset with two words queued
    send_word(8'h50, 8'h02);
    send_word(8'h60, 8'h02);
    for (int k = 0; k < 5; k++) step(1, 8'hE0 + 8'(k), 0);
    n_rst = 0;
    step(1, 8'hEE, 0);
    n_rst = 1;
    chk("mid_rst_count", word_count, 0);
    chk("mid_rst_data", fifo_data, 0);
    send_word(8'h70, 8'h03);
    chk("post_rst_word", fifo_data, {2'b11, 80'h79787776757473727170});
    step(0, 0, 1);
    // padding bits in byte 10
    send_word(8'h80, 8'h04);
`ifdef INST_BYTE_FIFO_PAD_CHECK_EN
    chk("pad_set", pad_err, 1);
    chk("pad_dropped", fifo_empty, 1);
`else
    chk("pad_ignored", fifo_data, {2'b00, 80'h89888786858483828180});
    step(0, 0, 1);
`endif
    send_word(8'h90, 8'h01);
`ifdef INST_BYTE_FIFO_PAD_CHECK_EN
    chk("pad_sticky", pad_err, 1);
`endif
    chk("after_pad_count", word_count, 1);
    chk("after_pad_data", fifo_data, {2'b01, 80'h99989796959493929190});
    repeat (3) step(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
